mem_write_sequencer: RTL

//  Arbitrates N independent write requesters (button decoder, game logic, init loader) onto one

---
 rtl/mem_seq_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/mem_write_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory write sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_seq_pkg;

  // Sequencer phases: grant, write strobe, read-back address, compare.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Saturating increment for the verify error counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, search starts at ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when to consume the grant.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requesters starting at ptr, wrapping, and take the first one set.
  always_comb begin
    int c;
    logic [IDX_W-1:0] cidx;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    cidx = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      cidx = IDX_W'(c);
      if (!any && req[cidx]) begin
        any       = 1'b1;
        idx       = cidx;
        gnt[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_sequencer.sv
// Serialises N requester writes round-robin onto one sync RAM port, optional read-back verify.
// Latency: mem_we 1 cycle after grant; ack at +3 (verify) or +1 (no verify).
// Backpressure: requesters hold req (level) until ack; one grant per IDLE cycle, others wait.
module mem_write_sequencer
  import mem_seq_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int VERIFY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic                    verify_err,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_gnt;
  logic             win_any;
  logic             mismatch;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  // Unpack the flat requester buses into per-requester lanes.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Pointer moves to the requester after the one just served, wrapping at N_REQ.
  assign next_ptr = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  assign busy = (state != IDLE);

  // mem_wdata still holds the latched write data, so it is the compare reference.
  // The sync RAM returns read-back data during CHECK, hence a combinational flag.
  assign mismatch   = (mem_rdata != mem_wdata);
  assign verify_err = (VERIFY != 0) && (state == CHECK) && mismatch;

  // Sequencer FSM: grant and latch, write strobe, optional read-back, ack and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack       <= '0;
    end else begin
      ack    <= '0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            gidx      <= win_idx;
            mem_addr  <= addr_arr[win_idx];
            mem_wdata <= data_arr[win_idx];
            mem_we    <= 1'b1;
            state     <= WRITE;
            // Without verify the ack coincides with the write strobe.
            if (VERIFY == 0) ack <= win_gnt;
          end
        end
        WRITE: begin
          if (VERIFY != 0) begin
            state <= READ;
          end else begin
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        READ: begin
          state <= CHECK;
          ack   <= ONE_HOT0 << gidx;
        end
        CHECK: begin
          state <= IDLE;
          ptr   <= next_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of read-back mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (verify_err) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule
